// File: rtl/reg_bank_reader.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_reader
// Description : Snapshots a bank of NREG registers on a start command and
//               streams the selected ones, in ascending index order, over a
//               valid/ready interface. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_reader #(
    parameter int bits = 8,
    parameter int NREG = 4,
    parameter int IW   = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NREG-1:0]      mask,
    input  logic [NREG*bits-1:0] reg_q,
    output logic [bits-1:0]      out_data,
    output logic [IW-1:0]        out_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [bits-1:0]     snap_q [NREG];
    logic [bits-1:0]     snap_d [NREG];
    logic [bits-1:0]     reg_in [NREG];
    logic [NREG-1:0]     pend_q, pend_d;
    logic [NREG-1:0]     pend_left;
    logic [IW-1:0]       lo_mask, lo_left;
    logic [bits-1:0]     out_data_q, out_data_d;
    logic [IW-1:0]       out_idx_q, out_idx_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Index of the lowest set bit; callers only use it on a non-zero vector.
    function automatic logic [IW-1:0] lowest_idx(input logic [NREG-1:0] v);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (v[i]) idx = IW'(i);
        end
        return idx;
    endfunction

    // Split the flattened register bus into one word per register.
    for (genvar g = 0; g < NREG; g++) begin : g_unpack
        assign reg_in[g] = reg_q[g*bits +: bits];
    end

    // Pending set with the currently presented register removed, i.e. what is
    // left once the consumer accepts the word on this edge.
    assign pend_left = pend_q & ~(NREG'(1) << out_idx_q);
    assign lo_mask   = lowest_idx(mask);
    assign lo_left   = lowest_idx(pend_left);

    // Next-state and next-output computation for the read sequencer.
    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        pend_d      = pend_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                if (start) begin
                    busy_d = 1'b1;
                    if (|mask) begin
                        // First word comes straight from the live bus, which
                        // is the same value the snapshot captures this edge.
                        snap_d      = reg_in;
                        pend_d      = mask;
                        out_idx_d   = lo_mask;
                        out_data_d  = reg_in[lo_mask];
                        out_valid_d = 1'b1;
                        state_d     = S_SEND;
                    end else begin
                        pend_d  = '0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_SEND: begin
                if (out_valid_q && out_ready) begin
                    pend_d = pend_left;
                    if (|pend_left) begin
                        out_idx_d  = lo_left;
                        out_data_d = snap_q[lo_left];
                    end else begin
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State, snapshot and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pend_q      <= '0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            for (int i = 0; i < NREG; i++) begin
                snap_q[i] <= snap_d[i];
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_reg_bank_reader
// Description : Self-checking bench for reg_bank_reader (NREG=4, bits=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank_reader;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [3:0]  mask;
    logic [31:0] reg_q;
    logic [7:0]  out_data;
    logic [1:0]  out_idx;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    reg_bank_reader #(.bits(8), .NREG(4)) dut (
        .clk       (clk),
        .reset     (reset_n),
        .start     (start),
        .mask      (mask),
        .reg_q     (reg_q),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs one start command. The expected stream is built from the rule
    // "every selected register, lowest index first, value as of start" and is
    // consumed whenever the bench accepts a word.
    task automatic run_seq(input logic [3:0] m, input logic [31:0] regs,
                           input bit rnd, input logic [63:0] rpat,
                           input bit scramble, input bit poke,
                           output int nvalid, output logic [7:0] first_data,
                           output int last_idx);
        int         ei[$];
        logic [7:0] ed[$];
        int         cyc;
        bit         got_done;
        bit         r;
        nvalid     = 0;
        first_data = 8'h00;
        last_idx   = -1;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                ei.push_back(i);
                ed.push_back(regs[i*8 +: 8]);
            end
        end
        @(negedge clk);
        mask      = m;
        reg_q     = regs;
        start     = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (scramble) begin
            reg_q        = $urandom;
            reg_q[15:8]  = 8'hFF;
            mask         = 4'($urandom);
        end
        cyc      = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 200) begin
            @(negedge clk);
            start = poke && (cyc == 0);
            if (poke && cyc == 0) mask = 4'b0001;
            if (ei.size() > 0) begin
                chk("valid", out_valid, 1);
                chk("busy", busy, 1);
                chk("done_early", done, 0);
                chk("idx", out_idx, ei[0]);
                chk("data", out_data, ed[0]);
                if (nvalid == 0) first_data = out_data;
                nvalid++;
                r = rnd ? ($urandom_range(0, 1) == 1) : rpat[cyc & 63];
                out_ready = r;
                if (r) begin
                    last_idx = int'(out_idx);
                    void'(ei.pop_front());
                    void'(ed.pop_front());
                end
            end else begin
                chk("valid_end", out_valid, 0);
                chk("done_pulse", done, 1);
                chk("busy_done", busy, 1);
                got_done  = 1'b1;
                out_ready = 1'b0;
            end
            cyc++;
        end
        if (!got_done) chk("timeout", 0, 1);
        @(negedge clk);
        start = 1'b0;
        chk("done_clear", done, 0);
        chk("busy_clear", busy, 0);
        chk("valid_idle", out_valid, 0);
    endtask

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] regs;
        int          exp_n;
        logic [7:0]  exp_first;
        int          exp_last;
    } vec_t;

    vec_t        tbl[6];
    int          nv;
    logic [7:0]  fd;
    int          li;

    initial begin
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        mask      = 4'h0;
        reg_q     = 32'h0;
        out_ready = 1'b0;

        tbl[0] = '{4'b1111, 32'h7E38_2800, 4, 8'h00, 3};
        tbl[1] = '{4'b1010, 32'h7E38_2800, 2, 8'h28, 3};
        tbl[2] = '{4'b0001, 32'h1122_3344, 1, 8'h44, 0};
        tbl[3] = '{4'b1000, 32'h1122_3344, 1, 8'h11, 3};
        tbl[4] = '{4'b0110, 32'hDEAD_BEEF, 2, 8'hBE, 2};
        tbl[5] = '{4'b0000, 32'hDEAD_BEEF, 0, 8'h00, -1};

        // Reset held for two cycles; outputs must be at their cleared values.
        repeat (2) begin
            @(negedge clk);
            chk("rst_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_data", out_data, 0);
            chk("rst_idx", out_idx, 0);
        end
        reset_n = 1'b1;

        // Table-driven sequences, consumer always ready.
        for (int t = 0; t < 6; t++) begin
            run_seq(tbl[t].mask, tbl[t].regs, 1'b0, '1, 1'b0, 1'b0, nv, fd, li);
            chk("tbl_count", nv, tbl[t].exp_n);
            chk("tbl_first", fd, tbl[t].exp_first);
            chk("tbl_last", li, tbl[t].exp_last);
        end

        // Sparse mask with the live bus changing after start: snapshot wins.
        run_seq(4'b1010, 32'h7E38_2800, 1'b0, '1, 1'b1, 1'b0, nv, fd, li);
        chk("snap_count", nv, 2);
        chk("snap_first", fd, 8'h28);

        // Backpressure: three stalled cycles then accept; word held for 4 cycles.
        run_seq(4'b0100, 32'h7E38_2800, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0, nv, fd, li);
        chk("bp_valid_cycles", nv, 4);
        chk("bp_data", fd, 8'h38);
        chk("bp_last", li, 2);

        // Start pulsed during SEND is ignored.
        run_seq(4'b1100, 32'h7E38_2800, 1'b0, '1, 1'b0, 1'b1, nv, fd, li);
        chk("busy_start_count", nv, 2);
        chk("busy_start_last", li, 3);

        // Asynchronous reset while idx 1 is presented.
        @(negedge clk);
        mask      = 4'b1111;
        reg_q     = 32'h7E38_2800;
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #3;
        chk("mid_idx", out_idx, 1);
        chk("mid_valid", out_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_data", out_data, 0);
        chk("arst_idx", out_idx, 0);
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b0;
        run_seq(4'b0110, 32'hA1B2_C3D4, 1'b0, '1, 1'b0, 1'b0, nv, fd, li);
        chk("post_rst_count", nv, 2);
        chk("post_rst_first", fd, 8'hC3);

        // Randomized sequences against the queue model.
        for (int k = 0; k < 20; k++) begin
            logic [3:0]  rm;
            logic [31:0] rr;
            rm = 4'($urandom);
            rr = $urandom;
            run_seq(rm, rr, 1'b1, '0, 1'b1, 1'b0, nv, fd, li);
            chk("rnd_count", nv >= $countones(rm) ? 1 : 0, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
